// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle 32-bit integer divider used by the execute stage for DIV/DIVU.
// Radix-2 restoring division, one quotient bit per clock, start/ready handshake.
//
// Handshake: the execute stage raises start_i and holds it (pipeline stalled)
// until it samples ready_o = 1. It drops start_i in the cycle it consumes the
// result; the unit then clears ready_o/result_o on the next edge and returns
// to idle. annul_i cancels a divide in progress (flush or exception).
//
// Ports:
//   clk           in   1   clock, rising edge
//   rst           in   1   synchronous, active-high reset
//   signed_div_i  in   1   1 = DIV (two's complement), 0 = DIVU
//   opdata1_i     in  32   dividend (captured at start)
//   opdata2_i     in  32   divisor  (captured at start)
//   start_i       in   1   divide request
//   annul_i       in   1   cancel the divide in progress
//   result_o      out 64   {remainder -> HI, quotient -> LO}, registered
//   ready_o       out  1   result_o valid, registered
// -----------------------------------------------------------------------------
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } state_e;

    state_e      state_q,    state_d;
    logic [5:0]  cnt_q,      cnt_d;
    logic [64:0] work_q,     work_d;
    logic [31:0] divisor_q,  divisor_d;
    logic        neg_quo_q,  neg_quo_d;
    logic        neg_rem_q,  neg_rem_d;
    logic [63:0] result_q,   result_d;
    logic        ready_q,    ready_d;

    logic [31:0] op1_mag;
    logic [31:0] op2_mag;
    logic [32:0] diff;
    logic [64:0] work_step;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        // Magnitudes of the live operands; only used at capture time.
        op1_mag = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        op2_mag = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

        // One restoring step: trial-subtract the divisor from the partial
        // remainder; a borrow (diff[32]) means the quotient bit is 0.
        diff      = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
        work_step = diff[32] ? {work_q[63:0], 1'b0}
                             : {diff[31:0], work_q[31:0], 1'b1};

        // Sign fix-up applied to the final step's value. The signed overflow
        // case 0x80000000 / -1 falls out naturally as quotient 0x80000000.
        quo_fix = neg_quo_q ? (~work_step[31:0] + 32'd1)  : work_step[31:0];
        rem_fix = neg_rem_q ? (~work_step[64:33] + 32'd1) : work_step[64:33];

        case (state_q)
            DIV_FREE: begin
                if (start_i && !annul_i) begin
                    divisor_d = op2_mag;
                    neg_quo_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                    neg_rem_d = signed_div_i && opdata1_i[31];
                    cnt_d     = 6'd0;
                    work_d    = {32'b0, op1_mag, 1'b0};
                    if (opdata2_i == 32'd0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        state_d = DIV_ON;
                    end
                end
            end
            DIV_BY_ZERO: begin
                result_d = 64'h0;
                if (annul_i) begin
                    state_d = DIV_FREE;
                    ready_d = 1'b0;
                end else begin
                    state_d = DIV_END;
                    ready_d = 1'b1;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d  = DIV_FREE;
                    ready_d  = 1'b0;
                    result_d = 64'h0;
                end else begin
                    work_d = work_step;
                    cnt_d  = cnt_q + 6'd1;
                    // cnt_q counts completed steps; this is the 32nd.
                    if (cnt_q == 6'd31) begin
                        state_d  = DIV_END;
                        result_d = {rem_fix, quo_fix};
                        ready_d  = 1'b1;
                    end
                end
            end
            DIV_END: begin
                // annul_i is deliberately ignored: the stage simply drops
                // start_i and the result goes unused.
                if (!start_i) begin
                    state_d  = DIV_FREE;
                    ready_d  = 1'b0;
                    result_d = 64'h0;
                end
            end
            default: begin
                state_d  = DIV_FREE;
                ready_d  = 1'b0;
                result_d = 64'h0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= 6'd0;
            work_q    <= 65'd0;
            divisor_q <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= 64'h0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Directed bench for div_unit. Inputs are driven on the falling edge, outputs
// are sampled on the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int total_cnt;
    int pass_cnt;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one divide and follow it through the handshake. The operands are
    // scrambled right after the start edge; the result must still reflect the
    // captured values.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_res,
                           input int exp_lat);
        int   n;
        logic got;
        logic early_bad;
        n         = 0;
        got       = 1'b0;
        early_bad = 1'b0;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);                    // E0
        @(negedge clk);
        signed_div_i = 1'($urandom_range(0, 1));
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        if (ready_o) begin
            got = 1'b1;
            n   = 0;
        end
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ready_o) got = 1'b1;
            else if (result_o !== 64'h0) early_bad = 1'b1;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " result_zero_before_ready"}, {63'd0, early_bad}, 64'd0);
        check({tag, " result"}, result_o, exp_res);
        // Stall for two more cycles: the result must hold.
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check({tag, " hold"}, {result_o[62:0], ready_o}, {exp_res[62:0], 1'b1});
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, " clear"}, {ready_o, result_o[62:0]}, 64'd0);
    endtask

    // Watch a window of cycles in which no result may appear.
    task automatic watch_idle(input string tag, input int cycles);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready_o !== 1'b0 || result_o !== 64'h0) bad = 1'b1;
        end
        check(tag, {63'd0, bad}, 64'd0);
    endtask

    initial begin
        total_cnt    = 0;
        pass_cnt     = 0;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ready", {63'd0, ready_o}, 64'd0);
        check("reset result", result_o, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic unsigned and signed cases.
        run_div("divu_100_7",  1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 32);
        run_div("div_m7_2",    1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 32);
        run_div("div_7_m2",    1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 32);
        run_div("div_m7_m2",   1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003, 32);
        run_div("divu_5_9",    1'b0, 32'd5,          32'd9,          64'h00000005_00000000, 32);
        run_div("divu_0_5",    1'b0, 32'd0,          32'd5,          64'h0,                 32);

        // Divide by zero, both signednesses.
        run_div("div_by_zero",  1'b1, 32'h12345678, 32'd0, 64'h0, 1);
        run_div("divu_by_zero", 1'b0, 32'h12345678, 32'd0, 64'h0, 1);

        // Overflow corner and its unsigned counterpart.
        run_div("div_ovf",  1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 32);
        run_div("divu_ovf", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 32);

        // Annul at E10 of DIVU 0xFFFFFFFF / 3.
        signed_div_i = 1'b0;
        opdata1_i    = 32'hFFFFFFFF;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        @(posedge clk);                    // E0
        repeat (9) @(posedge clk);         // E9
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);                    // E10
        @(negedge clk);
        annul_i = 1'b0;
        check("annul ready", {63'd0, ready_o}, 64'd0);
        check("annul result", result_o, 64'h0);
        watch_idle("annul no_result", 40);
        run_div("divu_after_annul", 1'b0, 32'hFFFFFFFF, 32'd3, 64'h00000000_55555555, 32);

        // Annul while in the divide-by-zero state.
        signed_div_i = 1'b0;
        opdata1_i    = 32'h12345678;
        opdata2_i    = 32'd0;
        start_i      = 1'b1;
        @(posedge clk);                    // E0
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);                    // E1
        @(negedge clk);
        annul_i = 1'b0;
        watch_idle("annul_zero no_result", 5);

        // start together with annul in idle is ignored.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        annul_i      = 1'b1;
        watch_idle("start_annul ignored", 4);
        start_i = 1'b0;
        annul_i = 1'b0;
        watch_idle("start_annul still_idle", 36);

        // Reset mid-divide at E15.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);                    // E0
        repeat (14) @(posedge clk);        // E14
        @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk);                    // E15
        @(negedge clk);
        check("mid_reset ready", {63'd0, ready_o}, 64'd0);
        check("mid_reset result", result_o, 64'h0);
        rst = 1'b0;
        watch_idle("mid_reset no_result", 40);
        run_div("div_after_reset", 1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 32);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
